instr_fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the MIPS datapath. Holds the PC and fetches one word per request from instruction memory over a req/ack handshake. Registers the instruction and PC+4 for the decode stage, and supplies `op_code` (bits 31:26) straight to `main_control`. Handles decode stalls with a one-entry skid register and branch redirects with a flush and a stale-response drop.

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch: MIPS instruction-fetch stage plus IF/ID pipeline register.
//
// The PC is held here, and one word is fetched per request over a req/ack
// handshake. The stage registers the instruction and PC+4 for decode. A
// one-entry skid register absorbs the word that arrives while decode is
// stalled. A branch redirect flushes IF/ID, and a response that is still in
// flight when the redirect hits is dropped.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr  fetch request and word-aligned address
//   imem_ack/imem_rdata response valid and instruction word
//   stall               decode cannot accept; hold IF/ID
//   redirect/redirect_pc taken branch and its target (bits [1:0] ignored)
//   if_valid/if_instr/if_pc4  IF/ID register contents
//   op_code             if_instr[31:26], combinational, to main_control
// ----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [PC_W-1:0] if_pc4,
   output logic [5:0]      op_code
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrop} state_e;

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] drop_addr_q;
   logic [31:0]     skid_instr_q;
   logic [PC_W-1:0] skid_pc4_q;
   logic            valid_q;
   logic [31:0]     instr_q;
   logic [PC_W-1:0] pc4_q;

   logic [PC_W-1:0] pc_plus4;
   logic [PC_W-1:0] target_pc;
   logic            unused_rpc_bits;

   // Modulo 2^PC_W, so the last word of the address space wraps to 0.
   assign pc_plus4        = pc_q + PC_W'(4);
   assign target_pc       = {redirect_pc[PC_W-1:2], 2'b00};
   assign unused_rpc_bits = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         drop_addr_q  <= RESET_PC;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc4_q        <= '0;
      end else if (redirect) begin
         // A redirect overrides a stall; the skid is discarded.
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc4_q        <= '0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
         pc_q         <= target_pc;
         case (state_q)
            StFetch: begin
               if (!imem_ack) begin
                  // Keep presenting the old address until its ack is dropped.
                  state_q     <= StDrop;
                  drop_addr_q <= pc_q;
               end else begin
                  state_q <= StFetch;
               end
            end
            StDrop:  state_q <= imem_ack ? StFetch : StDrop;
            default: state_q <= StFetch;
         endcase
      end else begin
         case (state_q)
            StIdle: state_q <= StFetch;
            StFetch: begin
               if (imem_ack) begin
                  pc_q <= pc_plus4;
                  if (!valid_q || !stall) begin
                     valid_q <= 1'b1;
                     instr_q <= imem_rdata;
                     pc4_q   <= pc_plus4;
                  end else begin
                     skid_instr_q <= imem_rdata;
                     skid_pc4_q   <= pc_plus4;
                     state_q      <= StHold;
                  end
               end else if (valid_q && !stall) begin
                  // Decode took the word and nothing replaces it: read as nop.
                  valid_q <= 1'b0;
                  instr_q <= '0;
                  pc4_q   <= '0;
               end
            end
            StHold: begin
               if (!stall) begin
                  valid_q <= 1'b1;
                  instr_q <= skid_instr_q;
                  pc4_q   <= skid_pc4_q;
                  state_q <= StFetch;
               end
            end
            StDrop: begin
               if (imem_ack) begin
                  state_q <= StFetch;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign imem_req  = (state_q == StFetch) || (state_q == StDrop);
   assign imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;
   assign if_valid  = valid_q;
   assign if_instr  = instr_q;
   assign if_pc4    = pc4_q;
   assign op_code   = instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch: directed bench for instr_fetch. The memory is a small
// lookup table; it either acks in the request cycle (zero_wait) or under
// manual control (man_ack). Outputs are sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic [5:0]  op_code;

   logic        zero_wait;
   logic        man_ack;

   int          n_checks;
   int          n_errors;

   instr_fetch #(
      .PC_W     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc4      (if_pc4),
      .op_code     (op_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h8C08_0004;
         32'h0000_0004: mem_word = 32'hAC09_0008;
         32'h0000_0008: mem_word = 32'h1234_5678;
         32'h0000_000C: mem_word = 32'h0000_0020;
         32'h0000_0040: mem_word = 32'h2108_0001;
         32'h0000_0080: mem_word = 32'h0800_0000;
         32'hFFFF_FFFC: mem_word = 32'h1000_FFFF;
         default:       mem_word = 32'hFFFF_FFFF;
      endcase
   endfunction

   assign imem_ack   = zero_wait ? imem_req : man_ack;
   assign imem_rdata = mem_word(imem_addr);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, " req"},   32'(imem_req),  32'd0);
      check_eq({tag, " addr"},  imem_addr,      32'h0);
      check_eq({tag, " valid"}, 32'(if_valid),  32'd0);
      check_eq({tag, " instr"}, if_instr,       32'h0);
      check_eq({tag, " pc4"},   if_pc4,         32'h0);
      check_eq({tag, " op"},    32'(op_code),   32'd0);
   endtask

   // Reset for 3 cycles, release off-edge, then step into the first FETCH cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      logic [31:0] exp_pc4;
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      zero_wait   = 1'b1;
      man_ack     = 1'b0;

      // Reset and startup.
      #7;
      check_reset_outputs("reset");
      do_reset();
      check_eq("start req",  32'(imem_req), 32'd1);
      check_eq("start addr", imem_addr,     32'h0);
      step();
      check_eq("start op",   32'(op_code),  32'(6'b100011));

      // Streaming: one word per cycle, if_pc4 = 4, 8, C, 10.
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         exp_pc4 = 32'(4 * (i + 1));
         check_eq("stream valid", 32'(if_valid), 32'd1);
         check_eq("stream pc4",   if_pc4,        exp_pc4);
      end
      zero_wait = 1'b0;
      step();
      check_eq("drain valid", 32'(if_valid), 32'd0);
      check_eq("drain instr", if_instr,      32'h0);

      // Stall with skid.
      zero_wait = 1'b1;
      do_reset();
      step();
      stall = 1'b1;
      step();
      check_eq("skid valid", 32'(if_valid), 32'd1);
      check_eq("skid op",    32'(op_code),  32'(6'b100011));
      check_eq("skid pc4",   if_pc4,        32'h4);
      check_eq("skid req",   32'(imem_req), 32'd0);
      step();
      check_eq("hold req",   32'(imem_req), 32'd0);
      check_eq("hold pc4",   if_pc4,        32'h4);
      stall = 1'b0;
      step();
      check_eq("unskid valid", 32'(if_valid), 32'd1);
      check_eq("unskid op",    32'(op_code),  32'(6'b101011));
      check_eq("unskid pc4",   if_pc4,        32'h8);
      zero_wait = 1'b0;
      check_eq("wait req",  32'(imem_req), 32'd1);
      check_eq("wait addr", imem_addr,     32'h8);

      // Redirect while the addr-8 request waits for its ack.
      step();
      check_eq("wait consumed", 32'(if_valid), 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_eq("drop req",   32'(imem_req), 32'd1);
         check_eq("drop addr",  imem_addr,     32'h8);
         check_eq("drop valid", 32'(if_valid), 32'd0);
         if (i == 0) step();
      end
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      check_eq("stale valid", 32'(if_valid), 32'd0);
      check_eq("stale instr", if_instr,      32'h0);
      check_eq("target req",  32'(imem_req), 32'd1);
      check_eq("target addr", imem_addr,     32'h40);
      zero_wait = 1'b1;
      step();
      check_eq("target valid", 32'(if_valid), 32'd1);
      check_eq("target instr", if_instr,      32'h2108_0001);
      check_eq("target pc4",   if_pc4,        32'h44);

      // Redirect, ack and stall in one cycle: the flush wins.
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0080;
      step();
      stall = 1'b0;
      check_eq("rsa valid", 32'(if_valid), 32'd0);
      check_eq("rsa op",    32'(op_code),  32'd0);
      check_eq("rsa req",   32'(imem_req), 32'd1);
      check_eq("rsa addr",  imem_addr,     32'h80);

      // Wrap: low target bits are ignored and FFFF_FFFC + 4 wraps to 0.
      redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      check_eq("wrap addr",  imem_addr,     32'hFFFF_FFFC);
      check_eq("wrap flush", 32'(if_valid), 32'd0);
      step();
      check_eq("wrap valid", 32'(if_valid), 32'd1);
      check_eq("wrap instr", if_instr,      32'h1000_FFFF);
      check_eq("wrap pc4",   if_pc4,        32'h0);
      check_eq("wrap next",  imem_addr,     32'h0);

      // Async reset mid-request, away from any clock edge.
      zero_wait = 1'b0;
      step();
      check_eq("pre-rst req", 32'(imem_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
